// File: rtl/rr_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// rr_dispatch_pkg
//
// Shared definitions for the round-robin dispatcher and its picker.
//
//   STAT_CNT_W  : width of each per-output delivery counter (stats build only,
//                 enabled by defining RR_DISPATCH_STATS_EN).
//   MAX_OUTPUTS : largest port count the onehot() helper can encode.
//   onehot_t    : return type of onehot(); callers size-cast it down to N bits.
//   ptr_width() : pointer width for a given port count (never below 1 bit).
//   onehot()    : idx -> one-hot vector, all-zero when idx is out of range.
// ---------------------------------------------------------------------------
package rr_dispatch_pkg;

    localparam int unsigned STAT_CNT_W  = 16;
    localparam int unsigned MAX_OUTPUTS = 64;

    typedef logic [MAX_OUTPUTS-1:0] onehot_t;

    // Width of a pointer that indexes n ports.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot encode idx within an n-bit field. A shift is used instead of a
    // variable bit-select so the index width never has to match the vector.
    function automatic onehot_t onehot(input int unsigned idx, input int unsigned n);
        onehot_t v;
        v = '0;
        if (idx < n) begin
            v = onehot_t'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational rotated find-first-set. Starting at ptr_i and wrapping
// modulo N_OF_OUTPUTS, returns the first index whose enable bit is set.
//
// Parameters:
//   N_OF_OUTPUTS : number of candidates (>= 2).
//   PTR_W        : index width, derived from N_OF_OUTPUTS by default.
//
// Ports:
//   ptr_i    in  PTR_W         first candidate searched (highest priority).
//   en_i     in  N_OF_OUTPUTS  candidate mask.
//   pick_o   out PTR_W         selected index; 0 when no bit is set.
//   any_en_o out 1             at least one candidate is enabled.
// ---------------------------------------------------------------------------
module rr_pick
    import rr_dispatch_pkg::*;
#(
    parameter int unsigned N_OF_OUTPUTS = 2,
    parameter int unsigned PTR_W        = ptr_width(N_OF_OUTPUTS)
) (
    input  logic [PTR_W-1:0]        ptr_i,
    input  logic [N_OF_OUTPUTS-1:0] en_i,
    output logic [PTR_W-1:0]        pick_o,
    output logic                    any_en_o
);

    // Mask rotated so that bit 0 corresponds to ptr_i. Duplicating the mask
    // and shifting right gives the wrap-around without modulo indexing.
    logic [N_OF_OUTPUTS-1:0] en_rot;

    assign en_rot   = N_OF_OUTPUTS'({en_i, en_i} >> ptr_i);
    assign any_en_o = |en_i;

    always_comb begin
        logic             found;
        logic [PTR_W:0]   sum;

        found  = 1'b0;
        sum    = '0;
        pick_o = '0;
        for (int unsigned k = 0; k < N_OF_OUTPUTS; k++) begin
            if (!found && en_rot[k]) begin
                found = 1'b1;
                // Map the rotated offset back to an absolute port index.
                sum   = {1'b0, ptr_i} + (PTR_W + 1)'(k);
                if (sum >= (PTR_W + 1)'(N_OF_OUTPUTS)) begin
                    sum = sum - (PTR_W + 1)'(N_OF_OUTPUTS);
                end
                pick_o = sum[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_dispatcher.sv
// ---------------------------------------------------------------------------
// rr_dispatcher
//
// Round-robin distributor: one valid/ready producer stream is fanned out
// across N_OF_OUTPUTS consumer ports. Every accepted beat goes to the next
// enabled port after the one that received the previous beat. A single
// registered holding stage carries the beat; it can drain and refill in the
// same cycle, so a ready consumer set sees one beat per cycle.
//
// A held beat is sticky: its destination and payload never change until it
// drains, even if the enable of that destination drops. Enables only steer
// future picks.
//
// Optional build: define RR_DISPATCH_STATS_EN to add per-output saturating
// delivery counters on stat_cnt_o (port i at bits [i*STAT_CNT_W +: STAT_CNT_W]).
//
// Parameters:
//   N_OF_OUTPUTS : number of consumer ports (>= 2).
//   DATA_WIDTH   : payload width.
//
// Ports:
//   clk          in  1                clock, all state on posedge.
//   arst         in  1                synchronous active-high reset.
//   en_i         in  N_OF_OUTPUTS     per-port enable for future picks.
//   in_valid_i   in  1                producer beat valid.
//   in_data_i    in  DATA_WIDTH       producer payload.
//   in_ready_o   out 1                beat is accepted this cycle if valid.
//   out_valid_o  out N_OF_OUTPUTS     one-hot (or zero) per-port valid.
//   out_data_o   out DATA_WIDTH       payload shared by all ports.
//   out_ready_i  in  N_OF_OUTPUTS     per-port ready.
//   stat_cnt_o   out N*STAT_CNT_W     delivery counters (stats build only).
// ---------------------------------------------------------------------------
module rr_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int unsigned N_OF_OUTPUTS = 2,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [N_OF_OUTPUTS-1:0] en_i,
    input  logic                    in_valid_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    output logic                    in_ready_o,
    output logic [N_OF_OUTPUTS-1:0] out_valid_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    input  logic [N_OF_OUTPUTS-1:0] out_ready_i
`ifdef RR_DISPATCH_STATS_EN
    ,
    output logic [N_OF_OUTPUTS*STAT_CNT_W-1:0] stat_cnt_o
`endif
);

    localparam int unsigned PTR_W = ptr_width(N_OF_OUTPUTS);

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t LAST_IDX = ptr_t'(N_OF_OUTPUTS - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    ptr_t                    ptr_q, ptr_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [N_OF_OUTPUTS-1:0] hold_dest_q, hold_dest_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;

    // -----------------------------------------------------------------------
    // Pick and handshakes
    // -----------------------------------------------------------------------
    ptr_t                    pick;
    logic                    any_en;
    logic [N_OF_OUTPUTS-1:0] drain_vec;
    logic                    drain;
    logic                    accept;

    rr_pick #(
        .N_OF_OUTPUTS (N_OF_OUTPUTS),
        .PTR_W        (PTR_W)
    ) u_pick (
        .ptr_i    (ptr_q),
        .en_i     (en_i),
        .pick_o   (pick),
        .any_en_o (any_en)
    );

    // Per-port delivery this cycle; at most one bit set since dest is one-hot.
    assign drain_vec = hold_dest_q & out_ready_i & {N_OF_OUTPUTS{hold_valid_q}};
    assign drain     = |drain_vec;

    // Reset forces ready low so no beat is accepted into a stage being cleared.
    assign in_ready_o = ~arst & any_en & (~hold_valid_q | drain);
    assign accept     = in_valid_i & in_ready_o;

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        ptr_d        = ptr_q;
        hold_valid_d = hold_valid_q;
        hold_dest_d  = hold_dest_q;
        hold_data_d  = hold_data_q;

        if (accept) begin
            // Covers refill-on-drain too: the new beat simply replaces the old.
            hold_valid_d = 1'b1;
            hold_data_d  = in_data_i;
            hold_dest_d  = N_OF_OUTPUTS'(onehot(32'(pick), N_OF_OUTPUTS));
            ptr_d        = (pick == LAST_IDX) ? '0 : ptr_t'(pick + 1'b1);
        end else if (drain) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            ptr_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_dest_q  <= '0;
            hold_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            hold_valid_q <= hold_valid_d;
            hold_dest_q  <= hold_dest_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_valid_o = hold_valid_q ? hold_dest_q : '0;
    assign out_data_o  = hold_data_q;

`ifdef RR_DISPATCH_STATS_EN
    // -----------------------------------------------------------------------
    // Delivery counters, saturating at all-ones
    // -----------------------------------------------------------------------
    logic [STAT_CNT_W-1:0] cnt_q [N_OF_OUTPUTS];
    logic [STAT_CNT_W-1:0] cnt_d [N_OF_OUTPUTS];

    always_comb begin
        for (int unsigned i = 0; i < N_OF_OUTPUTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (drain_vec[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + STAT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_OF_OUTPUTS; i++) begin
            if (arst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        for (int unsigned i = 0; i < N_OF_OUTPUTS; i++) begin
            stat_cnt_o[i*STAT_CNT_W +: STAT_CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_rr_dispatcher.sv
module tb_rr_dispatcher;
    import rr_dispatch_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic [N-1:0]  en_i;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic [N-1:0]  out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [N-1:0]  out_ready_i;
`ifdef RR_DISPATCH_STATS_EN
    logic [N*STAT_CNT_W-1:0] stat_cnt_o;
`endif

    rr_dispatcher #(
        .N_OF_OUTPUTS (N),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .en_i        (en_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i)
`ifdef RR_DISPATCH_STATS_EN
        ,
        .stat_cnt_o  (stat_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: which port holds a beat, where the next search starts,
    // and how many beats each port has received.
    typedef struct {
        int            dest;
        logic [DW-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] drained_q[$];
    int           m_ptr  = 0;
    int           m_dest = 0;
    bit           m_hold = 1'b0;
    int           m_cnt[N];

    function automatic logic [N-1:0] oh(input int d);
        logic [N-1:0] r;
        r    = '0;
        r[d] = 1'b1;
        return r;
    endfunction

    // First enabled port at or after ptr, wrapping; -1 if none enabled.
    function automatic int model_pick(input int ptr, input logic [N-1:0] en);
        for (int k = 0; k < N; k++) begin
            if (en[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every clock edge, from inputs and its own state only.
    always @(posedge clk) begin
        int  p;
        bit  drn;
        bit  rdy;
        if (arst) begin
            m_hold = 1'b0;
            m_ptr  = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            p   = model_pick(m_ptr, en_i);
            drn = m_hold && out_ready_i[m_dest];
            rdy = (p >= 0) && (!m_hold || drn);
            if (drn) begin
                m_hold = 1'b0;
                if (m_cnt[m_dest] < 65535) m_cnt[m_dest]++;
            end
            if (in_valid_i && rdy) begin
                exp_q.push_back('{dest: p, data: in_data_i});
                m_dest = p;
                m_hold = 1'b1;
                m_ptr  = (p + 1) % N;
            end
        end
    end

    // Monitor: compares handshake outputs and pops the scoreboard on delivery.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_rdy;
        exp_rdy = !arst && (|en_i) && (!m_hold || out_ready_i[m_dest]);
        check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
        check("out_valid", 64'(out_valid_o), m_hold ? 64'(oh(m_dest)) : 64'd0);
        if (|(out_valid_o & out_ready_i)) begin
            drained_q.push_back(out_valid_o);
            if (exp_q.size() == 0) begin
                check("unexpected beat", 64'(out_valid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat dest", 64'(out_valid_o), 64'(oh(e.dest)));
                check("beat data", 64'(out_data_o), 64'(e.data));
            end
        end
    end

    task automatic set(input logic r, input logic [N-1:0] en, input logic v,
                       input logic [DW-1:0] d, input logic [N-1:0] rdy);
        arst        = r;
        en_i        = en;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] skip_exp [4];
        skip_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        // Reset and idle
        set(1'b1, 4'b1111, 1'b0, '0, 4'b1111);
        tick();
        tick();
        set(1'b0, 4'b1111, 1'b0, '0, 4'b1111);
        #1;
        check("reset in_ready", 64'(in_ready_o), 64'd1);
        check("reset out_valid", 64'(out_valid_o), 64'd0);
        check("reset out_data", 64'(out_data_o), 64'd0);

        // Even rotation, one beat per cycle
        drained_q.delete();
        for (int i = 0; i < 8; i++) begin
            set(1'b0, 4'b1111, 1'b1, DW'(32'hA0 + i), 4'b1111);
            #1;
            check("rotation in_ready", 64'(in_ready_o), 64'd1);
            tick();
        end
        set(1'b0, 4'b1111, 1'b0, '0, 4'b1111);
        tick();
        check("rotation count", 64'(drained_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("rotation dest", 64'(drained_q[i]), 64'(oh(i % 4)));
        end
`ifdef RR_DISPATCH_STATS_EN
        #1;
        for (int i = 0; i < N; i++) begin
            check("rotation stat", 64'(stat_cnt_o[i*STAT_CNT_W +: STAT_CNT_W]), 64'd2);
        end
`endif

        // Skip disabled ports
        drained_q.delete();
        for (int i = 0; i < 4; i++) begin
            set(1'b0, 4'b1010, 1'b1, DW'(32'hB0 + i), 4'b1111);
            tick();
        end
        set(1'b0, 4'b1010, 1'b0, '0, 4'b1111);
        tick();
        check("skip count", 64'(drained_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("skip dest", 64'(drained_q[i]), 64'(skip_exp[i]));
        end

        // Stall with sticky destination, enable dropped mid-stall
        drained_q.delete();
        set(1'b0, 4'b0100, 1'b1, DW'(32'h55), 4'b1011);
        tick();
        for (int c = 0; c < 5; c++) begin
            set(1'b0, (c >= 2) ? 4'b1011 : 4'b1111, 1'b1, DW'(32'h66), 4'b1011);
            #1;
            check("stall in_ready", 64'(in_ready_o), 64'd0);
            check("stall out_valid", 64'(out_valid_o), 64'b0100);
            check("stall out_data", 64'(out_data_o), 64'h55);
            tick();
        end
        set(1'b0, 4'b1011, 1'b0, '0, 4'b1111);
        tick();
        check("stall delivered", 64'(drained_q.size()), 64'd1);
        check("stall dest", 64'(drained_q[0]), 64'b0100);

        // Reset while a beat is held
        set(1'b0, 4'b0010, 1'b1, DW'(32'h77), 4'b0000);
        tick();
        check("pre-reset hold", 64'(out_valid_o), 64'b0010);
        set(1'b1, 4'b1111, 1'b0, '0, 4'b0000);
        tick();
        set(1'b0, 4'b1111, 1'b0, '0, 4'b0000);
        #1;
        check("post-reset out_valid", 64'(out_valid_o), 64'd0);
        set(1'b0, 4'b1111, 1'b1, DW'(32'h88), 4'b1111);
        tick();
        check("post-reset dest", 64'(out_valid_o), 64'b0001);
        check("post-reset data", 64'(out_data_o), 64'h88);
        set(1'b0, 4'b1111, 1'b0, '0, 4'b1111);
        tick();

        // All outputs disabled
        for (int c = 0; c < 3; c++) begin
            set(1'b0, 4'b0000, 1'b1, DW'(32'h99), 4'b1111);
            #1;
            check("disabled in_ready", 64'(in_ready_o), 64'd0);
            tick();
            check("disabled out_valid", 64'(out_valid_o), 64'd0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom),
                1'($urandom), DW'($urandom), 4'($urandom));
            tick();
        end

        // Flush
        set(1'b0, 4'b1111, 1'b0, '0, 4'b1111);
        tick();
        tick();
        tick();
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
`ifdef RR_DISPATCH_STATS_EN
        for (int i = 0; i < N; i++) begin
            check("final stat", 64'(stat_cnt_o[i*STAT_CNT_W +: STAT_CNT_W]), 64'(m_cnt[i]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_dispatcher.md
Name: rr_dispatcher

Overview:
- Round-robin distributor, the fan-out counterpart of the round-robin arbiter: one valid/ready input stream is split across N_OF_INPUTS... no: across N_OF_OUTPUTS consumer ports.
- Each accepted beat goes to the next enabled output in rotating order, so load is spread evenly across parallel engines.
- Single registered output stage.
- Sits between a shared producer (e.g. a request queue) and N replicated consumers whose grants the arbiter later recombines.

Parameters:
- N_OF_OUTPUTS, 2, number of consumer ports (>=2).
- DATA_WIDTH, 32, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- arst  input  1  reset; synchronous, active-high (sampled on posedge clk only).
- en_i  input  N_OF_OUTPUTS  per-output enable mask; a 0 bit removes that output from rotation.
- in_valid_i  input  1  producer beat valid.
- in_data_i  input  DATA_WIDTH  producer payload.
- in_ready_o  output  1  dispatcher can accept a beat this cycle.
- out_valid_o  output  N_OF_OUTPUTS  one-hot (or zero) valid per consumer.
- out_data_o  output  DATA_WIDTH  payload, shared by all consumers; meaningful only where out_valid_o is set.
- out_ready_i  input  N_OF_OUTPUTS  per-consumer ready.

Behaviour:
- State:
  - ptr_ff: next-candidate index, $clog2(N_OF_OUTPUTS) bits.
  - hold_valid_ff, hold_dest_ff (one-hot, N bits), hold_data_ff.
- Reset (arst=1 at posedge):
  - ptr_ff=0, hold_valid_ff=0, hold_dest_ff=0, hold_data_ff=0.
  - out_valid_o=0, out_data_o=0.
  - in_ready_o=0 while arst is high.
  - A held beat is discarded on reset mid-transfer; no partial handoff.
- Drain condition: drain = hold_valid_ff & |(hold_dest_ff & out_ready_i).
- Pick: first index i with en_i[i]=1, searching ptr_ff, ptr_ff+1, … mod N_OF_OUTPUTS (rotated priority).
  - any_en = |en_i.
- in_ready_o = any_en & (!hold_valid_ff | drain), combinational.
  - Same-cycle drain and refill is allowed, giving a throughput of 1 beat/cycle when the consumer is ready.
- Accept (in_valid_i & in_ready_o):
  - hold_data_ff <= in_data_i.
  - hold_dest_ff <= onehot(pick).
  - hold_valid_ff <= 1.
  - ptr_ff <= pick+1, wrapping N_OF_OUTPUTS-1 -> 0.
- Drain without accept: hold_valid_ff <= 0. ptr_ff is unchanged.
- Outputs:
  - out_valid_o = hold_valid_ff ? hold_dest_ff : 0.
  - out_data_o = hold_data_ff.
- Latency: 1 cycle from input accept to out_valid_o.
- Held beat is sticky:
  - Destination and data never change while held.
  - This holds even if en_i of that destination drops; en_i only affects future picks.
- Stall: destination not ready -> beat held indefinitely, in_ready_o=0 (given any_en).
- All en_i=0: in_ready_o=0. A held beat still drains normally.
- Single enabled output: every beat goes to it.
  - ptr_ff still advances to pick+1, so rotation resumes fairly once others are enabled.

Optional Feature:
- Macro RR_DISPATCH_STATS_EN.
- Defined:
  - Adds output port stat_cnt_o, N_OF_OUTPUTS*STAT_CNT_W wide.
  - One counter per output; counter i increments on each drain to output i.
  - Counters saturate at all-ones, are cleared by arst, and are read-only.
- Undefined: no port, no counters.
- Core dispatch behaviour is identical in both builds.

Decomposition:
- Package rr_dispatch_pkg:
  - STAT_CNT_W=16.
  - Function onehot(idx, N).
  - Type alias for pointer width derivation.
- Sub-module rr_pick (combinational rotated find-first-set):
  - Inputs: ptr, en mask. Outputs: pick index, any_en.
  - Natural to reuse, and testable standalone.

Test Plan:
- Reset/idle: N=4, en_i=4'b1111, arst for 2 cycles, release -> out_valid_o=0, in_ready_o=1, ptr=0.
- Even rotation: N=4, all enabled, all out_ready_i=1, data 0xA0..0xA7 on consecutive cycles:
  - out_valid_o sequence 0001,0010,0100,1000,0001…, each 1 cycle after accept.
  - in_ready_o stays 1 throughout.
- Skip disabled: en_i=4'b1010, 4 beats -> destinations 0010,1000,0010,1000.
- Stall and sticky: beat 0x55 to output 2 with out_ready_i[2]=0 for 5 cycles.
  - out_valid_o=0100 and data 0x55 are held; in_ready_o=0.
  - Drop en_i[2] mid-stall -> still delivered to output 2 when ready rises.
- Mid-transfer reset: beat held toward output 1 with ready low, assert arst for 1 cycle:
  - Next cycle out_valid_o=0, ptr=0.
  - The next accepted beat goes to output 0.
- All disabled: en_i=0 with in_valid_i=1 for 3 cycles -> in_ready_o=0, no out_valid_o.
  - With RR_DISPATCH_STATS_EN: counters after the rotation test read 2,2,2,2.
